captcha_keypad_input: RTL
=========================

# captcha_keypad_input

On-screen keypad entry stage for the CAPTCHA-3 flow. Once the display stage finishes, this block renders a 6×3 mouse-driven keypad on the 96×64 OLED and detects left-click edges. It hit-tests each click against the key grid and collects a six-entry answer of 5-bit character codes, with delete and confirm keys. When the answer is confirmed it raises a completion flag, and the result stage compares the six codes against the displayed sequence.

## Interface
Parameters:
- FLASH_CYCLES, 2_500_000: cycles a pressed key is highlighted (25 ms at 100 MHz)
- EMPTY_CODE, 5'd31: code held in unfilled slots

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  display stage finished; level, must stay high during entry
- mouse_left  in  1  left button level, asynchronous to clock
- mouse_x, mouse_y  in  12  cursor position; only values 0..95 / 0..63 are meaningful; same clock domain
- pixel_x, pixel_y  in  7  current OLED pixel
- pixel_data  out  16  RGB565 colour for (pixel_x, pixel_y)
- first_inp … sixth_inp  out  5 each  entered codes, slots 0..5
- is_complete  out  1  answer confirmed; sticky until reset
- led  out  16  [2:0] entry count, [15] is_complete, rest 0

## Operation
- States:
  - IDLE: clicks ignored.
  - ENTRY: entered when start=1.
  - DONE: entered on a valid OK.
  - DONE is left only by reset. start falling while in ENTRY returns the block to IDLE and clears all slots.
- Click detection:
  - mouse_left passes through two sync flops (s1, s2), then s3 = previous s2.
  - click = s2 & ~s3.
  - mouse_x/y are sampled on the click cycle.
  - A held button produces exactly one click.
- Hit-test (only when mouse_x<96 and 16≤mouse_y<64):
  - col = mouse_x[6:4], row = (mouse_y−16)>>4, key = row*6+col.
  - Keys 0..15 are character codes, key 16 = DEL, key 17 = OK.
  - Clicks outside this region are ignored.
- ENTRY actions:
  - Char key with count<6: slot[count] ← key, count+1.
  - Char key with count=6: ignored.
  - DEL with count>0: slot[count−1] ← EMPTY_CODE, count−1. DEL with count=0: ignored.
  - OK with count=6: is_complete ← 1, go to DONE. OK with count<6: ignored.
- Flash: every in-region click in ENTRY, including ignored ones, loads flash_key ← key and restarts the flash counter at FLASH_CYCLES. The counter decrements to 0, and the flash ends at 0.
- Rendering (combinational; priority high→low):
  - Cursor pixel (pixel_x==mouse_x && pixel_y==mouse_y): FFFF.
  - Cell border (pixel_x[3:0]∈{0,15} or (pixel_y−0)[3:0]∈{0,15}, over the whole screen): FFFF.
  - Slot row y<16: slot index pixel_x>>4; filled slot 07E0, empty 0000.
  - Keypad: flashing key F800; hovered key 001F; DEL interior FFE0; OK interior 07FF when count=6, else 0000; other keys 0000.
  - In IDLE, pixel_data = 0000.

## Timing
- Reset (async assert, sync release), all outputs:
  - state IDLE, count 0, slots EMPTY_CODE.
  - is_complete 0, flash counter 0.
  - sync flops 0, led 0.
- Latency: mouse_left rising, sampled at edge N, gives a slot/count/is_complete update visible after edge N+3.
- A click in the same cycle as start rising is ignored, because the block is still in IDLE.
- At most one action per click; no queuing.
- Reset mid-entry discards all slots immediately.
- pixel_data has zero-cycle latency from pixel_x/y.

## Test plan
- Reset low, then high with start=0; click key 3 → slots all 31, count 0, pixel_data 0000.
- start=1; click at (5,20), (20,20), (37,20), (53,20), (69,20), (85,20) → codes 0,1,2,3,4,5, led[2:0]=6; a 7th char click leaves everything unchanged.
- After 6 entries, click DEL at (69,52) → sixth_inp=31, count 5; then click OK at (85,52) → is_complete stays 0.
- Refill slot 5 with key 7, then click OK → is_complete=1 three edges after the mouse edge, led[15]=1; further clicks and DEL change nothing.
- Hold mouse_left high for 1000 cycles over key 2 → exactly one entry; F800 is shown inside key 2 for FLASH_CYCLES, then 001F (hover).
- Assert reset low mid-entry with count 4 → count 0 and all slots 31 asynchronously, with no clock edge required.

Source files
------------

// File: rtl/captcha_keypad_input.sv
// captcha_keypad_input: mouse-driven 6x3 on-screen keypad that collects a six-code answer
// and renders the keypad and the entered slots on a 96x64 RGB565 OLED.
module captcha_keypad_input #(
  parameter int unsigned FLASH_CYCLES = 2_500_000,
  parameter logic [4:0]  EMPTY_CODE   = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic [6:0]  pixel_x,
  input  logic [6:0]  pixel_y,
  output logic [15:0] pixel_data,
  output logic [4:0]  first_inp,
  output logic [4:0]  second_inp,
  output logic [4:0]  third_inp,
  output logic [4:0]  fourth_inp,
  output logic [4:0]  fifth_inp,
  output logic [4:0]  sixth_inp,
  output logic        is_complete,
  output logic [15:0] led
);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q;
  logic hit_q, hit_d;
  logic [4:0] key_q, key_d, flash_key_q, flash_key_d, mouse_key, pkey;
  logic [2:0] count_q, count_d;
  logic [4:0] slot_q [6];
  logic [4:0] slot_d [6];
  logic [FW-1:0] flash_q, flash_d;
  logic done_q, done_d;
  logic in_region, border;

  function automatic logic [4:0] key_of(input logic [2:0] r, input logic [2:0] c);
    return {2'b0, r} * 5'd6 + {2'b0, c};
  endfunction

  // keypad rows start at y=16, so row = y[6:4]-1 inside the region
  assign in_region = mouse_x < 12'd96 && mouse_y >= 12'd16 && mouse_y < 12'd64;
  assign mouse_key = key_of(mouse_y[6:4] - 3'd1, mouse_x[6:4]);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slot_d = slot_q;
    done_d = done_q;
    flash_key_d = flash_key_q;
    flash_d = flash_q != '0 ? flash_q - FW'(1) : flash_q;
    hit_d = s2_q & ~s3_q & in_region;
    key_d = hit_d ? mouse_key : key_q;
    if (state_q == IDLE) state_d = start ? ENTRY : IDLE;
    else if (state_q == ENTRY && !start) begin
      state_d = IDLE;
      count_d = 3'd0;
      for (int i = 0; i < 6; i++) slot_d[i] = EMPTY_CODE;
    end else if (state_q == ENTRY && hit_q) begin
      flash_key_d = key_q;
      flash_d = FW'(FLASH_CYCLES);
      if (key_q < 5'd16 && count_q < 3'd6) begin
        slot_d[count_q] = key_q;
        count_d = count_q + 3'd1;
      end else if (key_q == 5'd16 && count_q != 3'd0) begin
        slot_d[count_q - 3'd1] = EMPTY_CODE;
        count_d = count_q - 3'd1;
      end else if (key_q == 5'd17 && count_q == 3'd6) begin
        done_d = 1'b1;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      {s1_q, s2_q, s3_q, hit_q, done_q} <= '0;
      key_q <= '0;
      flash_key_q <= '0;
      count_q <= '0;
      flash_q <= '0;
      for (int i = 0; i < 6; i++) slot_q[i] <= EMPTY_CODE;
    end else begin
      state_q <= state_d;
      {s1_q, s2_q, s3_q} <= {mouse_left, s1_q, s2_q};
      hit_q <= hit_d;
      done_q <= done_d;
      key_q <= key_d;
      flash_key_q <= flash_key_d;
      count_q <= count_d;
      flash_q <= flash_d;
      slot_q <= slot_d;
    end
  end

  assign border = pixel_x[3:0] == 4'h0 || pixel_x[3:0] == 4'hF ||
                  pixel_y[3:0] == 4'h0 || pixel_y[3:0] == 4'hF;
  assign pkey = key_of(pixel_y[6:4] - 3'd1, pixel_x[6:4]);

  always_comb begin
    pixel_data = (state_q == IDLE) ? 16'h0000 :
      ({5'b0, pixel_x} == mouse_x && {5'b0, pixel_y} == mouse_y) ? 16'hFFFF :
      border ? 16'hFFFF :
      (pixel_y < 7'd16) ? (pixel_x[6:4] < count_q ? 16'h07E0 : 16'h0000) :
      (pixel_x >= 7'd96 || pixel_y >= 7'd64) ? 16'h0000 :
      (flash_q != '0 && pkey == flash_key_q) ? 16'hF800 :
      (in_region && pkey == mouse_key) ? 16'h001F :
      (pkey == 5'd16) ? 16'hFFE0 :
      (pkey == 5'd17 && count_q == 3'd6) ? 16'h07FF : 16'h0000;
  end

  assign {first_inp, second_inp, third_inp} = {slot_q[0], slot_q[1], slot_q[2]};
  assign {fourth_inp, fifth_inp, sixth_inp} = {slot_q[3], slot_q[4], slot_q[5]};
  assign is_complete = done_q;
  assign led = {done_q, 12'b0, count_q};
endmodule
